dot_layer_sched: RTL and testbench

//  Sequences one fully-connected layer on the shared `dot` accelerator: for each output neuron k,

---
 rtl/dot_pkg.sv | 39 +++
 rtl/dot_bias_act.sv | 33 +++
 rtl/dot_layer_sched.sv | 180 ++++++++++++++++++
 tb/tb_dot_layer_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot-accelerator layer scheduler.
//   - dot CSR word offsets used when programming the accelerator
//   - scheduler CSR word offsets seen by the CPU
//   - scheduler state enum
//   - Q16.16 fixed-point value type
package dot_pkg;

  // Register offsets on the dot accelerator's slave port
  localparam logic [3:0] DOT_START = 4'd0;
  localparam logic [3:0] DOT_W     = 4'd2;
  localparam logic [3:0] DOT_IF    = 4'd3;
  localparam logic [3:0] DOT_N     = 4'd5;

  // Scheduler CSR map
  localparam logic [3:0] CSR_START = 4'd0;
  localparam logic [3:0] CSR_WBASE = 4'd1;
  localparam logic [3:0] CSR_IFBAS = 4'd2;
  localparam logic [3:0] CSR_OBASE = 4'd3;
  localparam logic [3:0] CSR_BBASE = 4'd4;
  localparam logic [3:0] CSR_NIN   = 4'd5;
  localparam logic [3:0] CSR_NOUT  = 4'd6;
  localparam logic [3:0] CSR_RELU  = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_W,
    S_CFG_IF,
    S_CFG_N,
    S_GO,
    S_RES,
    S_B_RD,
    S_B_WT,
    S_O_WR,
    S_NEXT
  } sched_state_t;

  typedef logic signed [31:0] q16_16_t;

endpackage

// File: rtl/dot_bias_act.sv
// Combinational bias add + optional ReLU on Q16.16 values.
// The add saturates to the signed 32-bit range instead of wrapping.
// Ports:
//   acc     in  32  accumulated dot-product result (Q16.16, signed)
//   bias    in  32  bias term (Q16.16, signed)
//   relu_en in  1   clamp negative sums to zero
//   y       out 32  activated output (Q16.16, signed)
module dot_bias_act
  import dot_pkg::*;
(
  input  q16_16_t acc,
  input  q16_16_t bias,
  input  logic    relu_en,
  output q16_16_t y
);

  function automatic q16_16_t sat_add(input q16_16_t a, input q16_16_t b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    // Overflow shows up as the two top bits disagreeing; bit 32 is the true sign.
    if (s[32] != s[31]) begin
      return s[32] ? q16_16_t'(32'h8000_0000) : q16_16_t'(32'h7FFF_FFFF);
    end
    return q16_16_t'(s[31:0]);
  endfunction

  function automatic q16_16_t relu(input q16_16_t x, input logic en);
    return (en && x[31]) ? q16_16_t'(32'd0) : x;
  endfunction

  assign y = relu(sat_add(acc, bias), relu_en);

endmodule

// File: rtl/dot_layer_sched.sv
// Fully-connected layer sequencer for the shared dot accelerator.
// For each output neuron k: program dot (weights, input features, length),
// start it, read back the Q16.16 result, fetch bias[k] from SDRAM, apply
// saturating bias add and optional ReLU, and write out[k] to SDRAM.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   slave_*               CPU CSR port (Avalon-MM slave); CSR0 read stalls while busy
//   dot_*                 master to the dot accelerator's CSR port
//   mem_*                 master to SDRAM (pipelined reads with readdatavalid)
module dot_layer_sched
  import dot_pkg::*;
#(
  parameter int MAX_NEURONS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        dot_waitrequest,
  output logic [3:0]  dot_address,
  output logic        dot_read,
  input  logic [31:0] dot_readdata,
  output logic        dot_write,
  output logic [31:0] dot_writedata,
  input  logic        mem_waitrequest,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  output logic        mem_write,
  output logic [31:0] mem_writedata
);

  sched_state_t     state, state_nx;
  logic [31:0]      w_base, if_base, out_base, bias_base;
  logic [CNT_W-1:0] n_inputs, n_outputs, k;
  logic             relu_en;
  logic [31:0]      w_off;     // running k*n_inputs*4, mod 2^32
  logic [31:0]      k4;
  q16_16_t          dot_res, bias_val, act_out;
  logic             busy, start_go, more;

  assign busy     = (state != S_IDLE);
  assign start_go = !busy && slave_write && (slave_address == CSR_START) && (n_outputs != '0);
  assign k4       = 32'(k) << 2;
  assign more     = (32'(k) + 32'd1) < 32'(n_outputs);

  // Only a CSR0 read stalls; it releases once the layer is done.
  assign slave_waitrequest = rst_n && busy && slave_read && (slave_address == CSR_START);

  always_comb begin
    slave_readdata = 32'd0;
    case (slave_address)
      CSR_WBASE: slave_readdata = w_base;
      CSR_IFBAS: slave_readdata = if_base;
      CSR_OBASE: slave_readdata = out_base;
      CSR_BBASE: slave_readdata = bias_base;
      CSR_NIN:   slave_readdata = 32'(n_inputs);
      CSR_NOUT:  slave_readdata = 32'(n_outputs);
      CSR_RELU:  slave_readdata = {31'd0, relu_en};
      default:   slave_readdata = 32'd0;
    endcase
  end

  dot_bias_act u_act (
    .acc     (dot_res),
    .bias    (bias_val),
    .relu_en (relu_en),
    .y       (act_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      w_base    <= '0;
      if_base   <= '0;
      out_base  <= '0;
      bias_base <= '0;
      n_inputs  <= '0;
      n_outputs <= '0;
      relu_en   <= 1'b0;
      k         <= '0;
      w_off     <= '0;
      dot_res   <= '0;
      bias_val  <= '0;
    end else begin
      state <= state_nx;
      if (!busy && slave_write) begin
        case (slave_address)
          CSR_WBASE: w_base    <= slave_writedata;
          CSR_IFBAS: if_base   <= slave_writedata;
          CSR_OBASE: out_base  <= slave_writedata;
          CSR_BBASE: bias_base <= slave_writedata;
          CSR_NIN:   n_inputs  <= slave_writedata[CNT_W-1:0];
          CSR_NOUT:  n_outputs <= (slave_writedata > 32'(MAX_NEURONS)) ?
                                  CNT_W'(MAX_NEURONS) : slave_writedata[CNT_W-1:0];
          CSR_RELU:  relu_en   <= slave_writedata[0];
          default: ;
        endcase
      end
      if (start_go) begin
        k     <= '0;
        w_off <= '0;
      end
      if (state == S_RES && !dot_waitrequest) dot_res <= q16_16_t'(dot_readdata);
      if (state == S_B_WT && mem_readdatavalid) bias_val <= q16_16_t'(mem_readdata);
      if (state == S_NEXT) begin
        k     <= k + 1'b1;
        w_off <= w_off + (32'(n_inputs) << 2);
      end
    end
  end

  // Bus outputs are pure functions of state and held registers, so they stay
  // stable for as long as a slave holds waitrequest.
  always_comb begin
    state_nx      = state;
    dot_address   = 4'd0;
    dot_read      = 1'b0;
    dot_write     = 1'b0;
    dot_writedata = 32'd0;
    mem_address   = 32'd0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = 32'd0;
    case (state)
      S_IDLE: if (start_go) state_nx = S_CFG_W;
      S_CFG_W: begin
        dot_write     = 1'b1;
        dot_address   = DOT_W;
        dot_writedata = w_base + w_off;
        if (!dot_waitrequest) state_nx = S_CFG_IF;
      end
      S_CFG_IF: begin
        dot_write     = 1'b1;
        dot_address   = DOT_IF;
        dot_writedata = if_base;
        if (!dot_waitrequest) state_nx = S_CFG_N;
      end
      S_CFG_N: begin
        dot_write     = 1'b1;
        dot_address   = DOT_N;
        dot_writedata = 32'(n_inputs);
        if (!dot_waitrequest) state_nx = S_GO;
      end
      S_GO: begin
        dot_write     = 1'b1;
        dot_address   = DOT_START;
        dot_writedata = 32'd1;
        if (!dot_waitrequest) state_nx = S_RES;
      end
      S_RES: begin
        // dot holds waitrequest until the dot product is finished
        dot_read    = 1'b1;
        dot_address = DOT_START;
        if (!dot_waitrequest) state_nx = S_B_RD;
      end
      S_B_RD: begin
        mem_read    = 1'b1;
        mem_address = bias_base + k4;
        if (!mem_waitrequest) state_nx = S_B_WT;
      end
      S_B_WT: if (mem_readdatavalid) state_nx = S_O_WR;
      S_O_WR: begin
        mem_write     = 1'b1;
        mem_address   = out_base + k4;
        mem_writedata = 32'(act_out);
        if (!mem_waitrequest) state_nx = S_NEXT;
      end
      S_NEXT: state_nx = more ? S_CFG_W : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dot_layer_sched.sv
`timescale 1ns/1ps
module tb_dot_layer_sched;
  import dot_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        dot_waitrequest;
  logic [3:0]  dot_address;
  logic        dot_read;
  logic [31:0] dot_readdata;
  logic        dot_write;
  logic [31:0] dot_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        mem_write;
  logic [31:0] mem_writedata;

  dot_layer_sched #(.MAX_NEURONS(1024), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
    .slave_read(slave_read), .slave_readdata(slave_readdata),
    .slave_write(slave_write), .slave_writedata(slave_writedata),
    .dot_waitrequest(dot_waitrequest), .dot_address(dot_address),
    .dot_read(dot_read), .dot_readdata(dot_readdata),
    .dot_write(dot_write), .dot_writedata(dot_writedata),
    .mem_waitrequest(mem_waitrequest), .mem_address(mem_address),
    .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_write(mem_write),
    .mem_writedata(mem_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-neuron vectors: dot result, bias, expected output (hand computed)
  typedef struct {
    logic [31:0] res;
    logic [31:0] bias;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  // Scoreboard queues, filled when a layer is set up, drained by the slave models
  xfer_t       dot_q[$];
  xfer_t       mem_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] res_arr[16];
  logic [31:0] bias_arr[16];
  logic [31:0] bias_base_m;
  int          res_idx;
  bit          stall_en;
  bit          spur_en;
  int          mem_wr_seen;
  int          dot_rd_seen;

  function automatic logic [31:0] bias_lookup(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - bias_base_m) >> 2;
    return (idx < 16) ? bias_arr[idx[3:0]] : 32'hBAD0_BAD0;
  endfunction

  // dot slave + SDRAM slave models
  initial begin : responder
    int          dot_stall, mem_stall, rd_dly;
    bit          dot_busy, mem_busy, rd_pend, dot_pw, mem_pw;
    logic [31:0] rd_data, ea;
    logic [63:0] dsnap_ctl, dsnap_data, msnap_ctl, msnap_data;
    xfer_t       x;
    dot_waitrequest = 1'b0; dot_readdata = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
    dot_busy = 0; mem_busy = 0; rd_pend = 0; dot_pw = 0; mem_pw = 0;
    dot_stall = 0; mem_stall = 0; rd_dly = 0; rd_data = '0;
    dsnap_ctl = '0; dsnap_data = '0; msnap_ctl = '0; msnap_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dot_busy = 0; mem_busy = 0; rd_pend = 0; dot_pw = 0; mem_pw = 0;
        dot_waitrequest = 1'b0; mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0;
      end else begin
        if ((dot_read || dot_write) || (mem_read || mem_write))
          check("bus_excl", 64'((dot_read || dot_write) && (mem_read || mem_write)), 64'd0);
        if (dot_pw) begin
          check("dot_stable_ctl", {58'd0, dot_read, dot_write, dot_address}, dsnap_ctl);
          check("dot_stable_data", 64'(dot_writedata), dsnap_data);
        end
        if (mem_pw) begin
          check("mem_stable_ctl", {30'd0, mem_read, mem_write, mem_address}, msnap_ctl);
          check("mem_stable_data", 64'(mem_writedata), msnap_data);
        end
        // read response path; stray valids only while no read is outstanding
        mem_readdatavalid = 1'b0;
        if (rd_pend) begin
          if (rd_dly == 0) begin
            mem_readdatavalid = 1'b1; mem_readdata = rd_data; rd_pend = 0;
          end else rd_dly--;
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
          mem_readdatavalid = 1'b1; mem_readdata = 32'hDEAD_BEEF;
        end
        // dot port
        dot_pw = 0;
        dot_waitrequest = 1'b0;
        if (dot_read || dot_write) begin
          if (!dot_busy) begin
            dot_busy  = 1;
            dot_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
            if (dot_read) dot_stall += 3;
          end
          if (dot_stall > 0) begin
            dot_waitrequest = 1'b1; dot_stall--; dot_pw = 1;
            dsnap_ctl  = {58'd0, dot_read, dot_write, dot_address};
            dsnap_data = 64'(dot_writedata);
          end else begin
            dot_busy = 0;
            if (dot_write) begin
              n_checks++;
              if (dot_q.size() == 0) begin
                n_errors++;
                $display("FAIL dot_unexpected: got write 0x%0h to %0d expected none", dot_writedata, dot_address);
              end else begin
                x = dot_q.pop_front();
                check("dot_wr_addr", 64'(dot_address), 64'(x.addr));
                check("dot_wr_data", 64'(dot_writedata), 64'(x.data));
              end
            end else begin
              check("dot_rd_addr", 64'(dot_address), 64'(DOT_START));
              dot_readdata = (res_idx < 16) ? res_arr[res_idx] : 32'hBAD0_0000;
              res_idx++;
              dot_rd_seen++;
            end
          end
        end
        // SDRAM port
        mem_pw = 0;
        mem_waitrequest = 1'b0;
        if (mem_read || mem_write) begin
          if (!mem_busy) begin
            mem_busy  = 1;
            mem_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
          end
          if (mem_stall > 0) begin
            mem_waitrequest = 1'b1; mem_stall--; mem_pw = 1;
            msnap_ctl  = {30'd0, mem_read, mem_write, mem_address};
            msnap_data = 64'(mem_writedata);
          end else begin
            mem_busy = 0;
            n_checks++;
            if (mem_read) begin
              if (rd_q.size() == 0) begin
                n_errors++;
                $display("FAIL mem_rd_unexpected: got read at 0x%0h expected none", mem_address);
              end else begin
                ea = rd_q.pop_front();
                check("bias_rd_addr", 64'(mem_address), 64'(ea));
              end
              rd_pend = 1;
              rd_dly  = $urandom_range(0, 3);
              rd_data = bias_lookup(mem_address);
            end else begin
              mem_wr_seen++;
              if (mem_q.size() == 0) begin
                n_errors++;
                $display("FAIL mem_wr_unexpected: got 0x%0h at 0x%0h expected none", mem_writedata, mem_address);
              end else begin
                x = mem_q.pop_front();
                check("out_wr_addr", 64'(mem_address), 64'(x.addr));
                check("out_wr_data", 64'(mem_writedata), 64'(x.data));
              end
            end
          end
        end
      end
    end
  end

  // CPU-side bus tasks; inputs change 1ns after the rising edge
  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output int cycles);
    @(posedge clk); #1;
    slave_address = a; slave_read = 1'b1; cycles = 0;
    forever begin
      #3;
      if (!slave_waitrequest || cycles >= 4000) break;
      @(posedge clk); #1;
      cycles++;
    end
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic setup_csrs(input bit relu, input int n_in, input int n_out, input logic [31:0] wb,
                            input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] bb);
    csr_write(CSR_WBASE, wb);
    csr_write(CSR_IFBAS, ib);
    csr_write(CSR_OBASE, ob);
    csr_write(CSR_BBASE, bb);
    csr_write(CSR_NIN, 32'(n_in));
    csr_write(CSR_NOUT, 32'(n_out));
    csr_write(CSR_RELU, {31'd0, relu});
  endtask

  task automatic push_cfg(input int i, input int n_in, input logic [31:0] wb, input logic [31:0] ib);
    logic [31:0] wa;
    wa = wb + 32'(i) * 32'(n_in) * 32'd4;
    dot_q.push_back('{32'(DOT_W), wa});
    dot_q.push_back('{32'(DOT_IF), ib});
    dot_q.push_back('{32'(DOT_N), 32'(n_in)});
    dot_q.push_back('{32'(DOT_START), 32'd1});
  endtask

  task automatic run_layer(input int first, input int n, input bit relu, input int n_in,
                           input logic [31:0] wb, input logic [31:0] ib, input logic [31:0] ob,
                           input logic [31:0] bb, input bit stall, input bit pokes);
    logic [31:0] d;
    int          cyc, rd0;
    stall_en = stall; spur_en = stall; res_idx = 0; bias_base_m = bb; rd0 = dot_rd_seen;
    for (int i = 0; i < n; i++) begin
      res_arr[i]  = tbl[first + i].res;
      bias_arr[i] = tbl[first + i].bias;
      push_cfg(i, n_in, wb, ib);
      rd_q.push_back(bb + 32'(i) * 32'd4);
      mem_q.push_back('{ob + 32'(i) * 32'd4, tbl[first + i].exp});
    end
    setup_csrs(relu, n_in, n, wb, ib, ob, bb);
    csr_write(CSR_START, 32'd1);
    if (pokes) begin
      csr_write(CSR_WBASE, 32'h5555);
      csr_write(CSR_START, 32'd1);
    end
    csr_read(CSR_START, d, cyc);
    check("layer_done_in_time", 64'(cyc < 4000), 64'd1);
    check("csr0_rd_value", 64'(d), 64'd0);
    check("dot_q_drained", 64'(dot_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("dot_rd_count", 64'(dot_rd_seen - rd0), 64'(n));
    if (pokes) begin
      csr_read(CSR_WBASE, d, cyc);
      check("csr1_busy_write_ignored", 64'(d), 64'(wb));
    end
    dot_q.delete(); mem_q.delete(); rd_q.delete();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    int          cyc, mw0, dr0, found;

    tbl[0]  = '{32'h0003_0000, 32'h0001_0000, 32'h0004_0000};
    tbl[1]  = '{32'hFFFE_0000, 32'h0001_0000, 32'hFFFF_0000};
    tbl[2]  = '{32'h0003_0000, 32'h0001_0000, 32'h0004_0000};
    tbl[3]  = '{32'hFFFE_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF};
    tbl[5]  = '{32'h8001_0000, 32'hFFFE_0000, 32'h8000_0000};
    tbl[6]  = '{32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1233};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    tbl[8]  = '{32'h8001_0000, 32'hFFFE_0000, 32'h0000_0000};
    tbl[9]  = '{32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF};
    tbl[10] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    rst_n = 1'b0; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    stall_en = 0; spur_en = 0; res_idx = 0; bias_base_m = '0; mem_wr_seen = 0; dot_rd_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {60'd0, dot_read, dot_write, mem_read, mem_write}, 64'd0);
    check("rst_dot_addr_data", {28'd0, dot_address, dot_writedata}, 64'd0);
    check("rst_mem_addr_data", {mem_address, mem_writedata}, 64'd0);
    check("rst_slave_wait", 64'(slave_waitrequest), 64'd0);
    rst_n = 1'b1;
    for (int a = 1; a < 8; a++) begin
      csr_read(4'(a), d, cyc);
      check("rst_csr_zero", 64'(d), 64'd0);
    end

    // CSR readback, clamp, relu bit
    csr_write(CSR_NOUT, 32'd5000);
    csr_read(CSR_NOUT, d, cyc);
    check("nout_clamp", 64'(d), 64'd1024);
    csr_write(CSR_RELU, 32'hFFFF_FFFF);
    csr_read(CSR_RELU, d, cyc);
    check("relu_bit0_only", 64'(d), 64'd1);
    csr_write(CSR_OBASE, 32'hCAFE_0000);
    csr_read(CSR_OBASE, d, cyc);
    check("csr3_readback", 64'(d), 64'hCAFE_0000);

    // start with n_outputs = 0: no traffic, stays idle
    dr0 = dot_rd_seen; mw0 = mem_wr_seen;
    csr_write(CSR_NOUT, 32'd0);
    csr_write(CSR_START, 32'd1);
    repeat (20) @(posedge clk);
    csr_read(CSR_START, d, cyc);
    check("nout0_no_stall", 64'(cyc), 64'd0);
    check("nout0_no_traffic", 64'((dot_rd_seen - dr0) + (mem_wr_seen - mw0)), 64'd0);

    // table-driven layers
    run_layer(0, 2, 1'b0, 4, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0);
    run_layer(2, 2, 1'b1, 4, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0);
    run_layer(4, 4, 1'b0, 3, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, 1'b0);
    run_layer(8, 3, 1'b1, 4, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b1, 1'b1);
    run_layer(4, 2, 1'b0, 8, 32'hFFFF_FFF0, 32'h2000, 32'h5000, 32'h6000, 1'b1, 1'b0);

    // reset while waiting on the dot result
    stall_en = 0; spur_en = 0; res_idx = 0; bias_base_m = 32'h4000;
    res_arr[0] = tbl[0].res; bias_arr[0] = tbl[0].bias;
    push_cfg(0, 4, 32'h1000, 32'h2000);
    setup_csrs(1'b0, 4, 2, 32'h1000, 32'h2000, 32'h3000, 32'h4000);
    mw0 = mem_wr_seen;
    csr_write(CSR_START, 32'd1);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dot_read) begin found = 1; break; end
    end
    check("reach_res", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_strobes", {60'd0, dot_read, dot_write, mem_read, mem_write}, 64'd0);
    rst_n = 1'b1;
    check("midrst_cfg_done", 64'(dot_q.size()), 64'd0);
    dot_q.delete(); mem_q.delete(); rd_q.delete();
    repeat (30) @(posedge clk);
    check("midrst_no_mem_write", 64'(mem_wr_seen - mw0), 64'd0);
    csr_read(CSR_WBASE, d, cyc);
    check("midrst_csr1_cleared", 64'(d), 64'd0);
    run_layer(0, 2, 1'b0, 4, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
